conv_add_tree_acc: RTL and testbench
====================================

# conv_add_tree_acc

Parametrised, fully pipelined signed adder tree with bias injection and a group accumulator. It reduces NUM_IN WIDTH-bit operands plus one bias word per beat. It then sums tree results across a multi-beat group, e.g. input-channel slices of one convolution output, and emits one result per group. It sits after the multiplier array in the convolution datapath and feeds the activation stage.

## Interface
- NUM_IN, 25: operands per beat, 1..64.
- WIDTH, 16: operand, bias, internal and output width; two's complement.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat qualifier.
- in_last  in  1  final beat of the current group; sampled only with in_valid.
- in_data  in  WIDTH*NUM_IN  operand k at bits [WIDTH*k +: WIDTH].
- in_bias  in  WIDTH  bias; added only on the in_last beat.
- out_valid  out  1  one-cycle pulse per completed group.
- out_data  out  WIDTH  group sum; holds its last value while out_valid is low.

## Operation
- Bias handling:
  - Tree operand count is M = NUM_IN+1; operand NUM_IN is the bias.
  - The bias operand is forced to 0 when in_last=0.
- Tree structure:
  - Number of levels L = ceil(log2(M)); for the default, M=26 and L=5.
  - Each level pairs adjacent operands in index order: (0,1), (2,3), and so on.
  - An odd leftover operand is registered unchanged, as if added to 0.
  - Every level is one register stage.
- Valid and last tracking:
  - A valid bit and a last bit travel alongside the data through all L stages.
  - Data registers load only when their stage valid bit is set.
- Accumulator stage (stage L+1), with register acc, reset value 0, on a valid tree result T:
  - Tree last=0: acc <= acc+T; out_valid stays 0.
  - Tree last=1: out_data <= acc+T; out_valid <= 1; acc <= 0.
- A group of one beat (in_last=1 on every beat) gives a plain tree sum plus bias.
- No back-pressure and no stall: a new beat may be accepted every cycle. Groups can run back-to-back with no idle cycle between them.
- Arithmetic:
  - All adds are signed WIDTH-bit.
  - Overflow behaviour is set by Configuration; it applies to every tree adder and to the accumulator.
- Reset, at any time:
  - All valid bits, acc, out_valid and out_data go to 0.
  - Beats in flight and any partially accumulated group are discarded.
  - The first beat accepted after reset deasserts starts a new group.

## Timing
- Latency: a beat accepted with in_valid=1 and in_last=1 at edge n produces out_valid=1 in the cycle following edge n+L+1.
  - Default latency is 6 cycles.
  - For NUM_IN=1, latency is 2 cycles.
- Throughput: one beat per cycle, and one result per group.
- out_valid is never high on two consecutive cycles unless consecutive beats each carry in_last=1.
- in_last with in_valid=0 is ignored.
- Reset values: out_valid=0, out_data=0.
- Internal: all stage registers and acc reset to 0.

## Configuration
- ADDTREE_SAT_EN:
  - Defined: every adder and the accumulator saturate, to 2^(WIDTH-1)-1 on positive overflow and -2^(WIDTH-1) on negative overflow.
  - Undefined: results wrap modulo 2^WIDTH.
- Latency and handshake are identical in both builds.

## Test plan
- Single beat with defaults: all 25 operands = 1, bias = 3, in_last=1 -> out_data = 28 (0x001C), with out_valid pulsing exactly 6 cycles after acceptance.
- Back-to-back single-beat groups: 10 consecutive beats, beat i with operands = i and bias = 0 -> 10 consecutive out_valid pulses with out_data = 25*i, in order.
- Three-beat group: operands all 2, 3, 4 per beat, bias 7 on the third beat only -> one pulse with out_data = 50+75+100+7 = 232, and no pulse for beats 1-2.
- Overflow: all operands 0x7FFF, bias 0 -> out_data = 0x7FFF with ADDTREE_SAT_EN defined; 16-bit wrapped sum 0x7FE7 without it. The negative case (all 0x8000) gives 0x8000 in both builds.
- Reset mid-group: 2 beats of a group in flight, rst pulsed for one cycle, then a single beat with operands 1 and bias 0 -> no output from the aborted group, and out_data = 25 with acc not carrying stale data.
- NUM_IN=1, NUM_IN=2 and NUM_IN=64 builds: random operands against a reference model -> exact match, and latencies of 2, 3 and 8 cycles respectively.

Source files
------------

// File: rtl/conv_add_tree_acc_if.sv
// Beat input and group-result output bundle for conv_add_tree_acc.
interface conv_add_tree_acc_if #(
  parameter int unsigned NUM_IN = 25,
  parameter int unsigned WIDTH  = 16
);
  logic                    in_valid;
  logic                    in_last;
  logic [WIDTH*NUM_IN-1:0] in_data;
  logic [WIDTH-1:0]        in_bias;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;

  modport master (
    output in_valid, in_last, in_data, in_bias,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_last, in_data, in_bias,
    output out_valid, out_data
  );
endinterface

// File: rtl/conv_add_tree_acc.sv
// Pipelined signed adder tree (NUM_IN operands + bias) feeding a per-group accumulator.
// Define ADDTREE_SAT_EN for saturating adds; otherwise all adds wrap modulo 2^WIDTH.
module conv_add_tree_acc #(
  parameter int unsigned NUM_IN = 25,
  parameter int unsigned WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  conv_add_tree_acc_if.slave  bus
);

  localparam int unsigned M = NUM_IN + 1;

  // Operand count surviving after l pairwise levels.
  function automatic int unsigned lvl_cnt(input int unsigned l);
    int unsigned c;
    c = M;
    for (int unsigned j = 0; j < l; j++) c = (c + 1) / 2;
    return c;
  endfunction

  localparam int unsigned L = $clog2(M);

  function automatic logic [WIDTH-1:0] add_w(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
`ifdef ADDTREE_SAT_EN
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [L:0] vld_d, vld_q;
  logic [L:0] lst_d, lst_q;

  always_comb begin
    vld_d = {vld_q[L-1:0], bus.in_valid};
    lst_d = {lst_q[L-1:0], bus.in_valid & bus.in_last};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  end

  // Level 0 captures operands and the masked bias; levels 1..L reduce pairwise.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int unsigned NC = lvl_cnt(l);
    logic [WIDTH-1:0] opnd_d [NC];
    logic [WIDTH-1:0] opnd_q [NC];
    logic             ld_c;

    if (l == 0) begin : g_en_in
      assign ld_c = bus.in_valid;
    end else begin : g_en_lvl
      assign ld_c = vld_q[l-1];
    end

    for (genvar i = 0; i < NC; i++) begin : g_op
      if (l == 0) begin : g_src
        if (i < NUM_IN) begin : g_dat
          assign opnd_d[i] = bus.in_data[WIDTH*i +: WIDTH];
        end else begin : g_bias
          assign opnd_d[i] = bus.in_last ? bus.in_bias : '0;
        end
      end else if (2*i + 1 < lvl_cnt(l-1)) begin : g_add
        assign opnd_d[i] = add_w(g_lvl[l-1].opnd_q[2*i], g_lvl[l-1].opnd_q[2*i+1]);
      end else begin : g_pass
        assign opnd_d[i] = g_lvl[l-1].opnd_q[2*i];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)       opnd_q <= '{default: '0};
      else if (ld_c) opnd_q <= opnd_d;
    end
  end

  logic [WIDTH-1:0] tree_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic             out_valid_d, out_valid_q;

  assign tree_c = g_lvl[L].opnd_q[0];

  // Group accumulator: fold tree results until the last beat, then emit and clear.
  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sum_c       = add_w(acc_q, tree_c);
    if (vld_q[L]) begin
      if (lst_q[L]) begin
        out_data_d  = sum_c;
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = sum_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_conv_add_tree_acc.sv
// Scoreboard bench for conv_add_tree_acc: randomized and directed beats vs. a queue-based tree/accumulator model.
module tb_conv_add_tree_acc;

  localparam int unsigned NUM_IN = 25;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned L      = $clog2(NUM_IN + 1);

  typedef logic [WIDTH-1:0]        word_t;
  typedef logic [WIDTH*NUM_IN-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_add_tree_acc_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) bus ();

  conv_add_tree_acc #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  longint edge_cnt = 0;
  word_t  exp_q[$];
  longint lat_q[$];
  word_t  acc_m = '0;
  word_t  last_out = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference signed add: wrap, or clamp to the WIDTH-bit range.
  function automatic word_t m_add(input word_t a, input word_t b);
    longint s, hi, lo;
    s  = longint'($signed(a)) + longint'($signed(b));
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (WIDTH - 1));
`ifdef ADDTREE_SAT_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    if (s > hi || s < lo) s = s;
`endif
    return word_t'(s);
  endfunction

  // Repeated pairwise reduction in index order; odd leftover passes through.
  function automatic word_t m_tree(input word_t ops_in[$]);
    word_t ops[$];
    word_t nx[$];
    ops = ops_in;
    while (ops.size() > 1) begin
      nx = {};
      for (int i = 0; i < ops.size(); i += 2) begin
        if (i + 1 < ops.size()) nx.push_back(m_add(ops[i], ops[i+1]));
        else                    nx.push_back(ops[i]);
      end
      ops = nx;
    end
    return ops[0];
  endfunction

  function automatic vec_t fill(input word_t v);
    vec_t r;
    for (int k = 0; k < NUM_IN; k++) r[WIDTH*k +: WIDTH] = v;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int k = 0; k < NUM_IN; k++) r[WIDTH*k +: WIDTH] = word_t'($urandom);
    return r;
  endfunction

  task automatic beat(input vec_t data, input word_t bias, input logic last);
    word_t ops[$];
    word_t t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_data  = data;
    bus.in_bias  = bias;
    for (int k = 0; k < NUM_IN; k++) ops.push_back(data[WIDTH*k +: WIDTH]);
    ops.push_back(last ? bias : word_t'(0));
    t = m_tree(ops);
    if (last) begin
      exp_q.push_back(m_add(acc_m, t));
      lat_q.push_back(edge_cnt + 1 + longint'(L) + 1);
      acc_m = '0;
    end else begin
      acc_m = m_add(acc_m, t);
    end
  endtask

  // Idle cycles carry junk data and in_last to show they are ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom);
      bus.in_data  = rand_vec();
      bus.in_bias  = word_t'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_m = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== word_t'(0)) begin
      n_err++;
      $display("FAIL reset_out_data: got %h, required %h", bus.out_data, word_t'(0));
    end
  endtask

  // Monitor: pop expected result on every pulse, check data, latency and hold.
  always @(negedge clk) begin
    word_t  e;
    longint le;
    if (rst) begin
      last_out = '0;
    end else if (bus.out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got out_valid=1 data=%h at edge %0d, required no output",
                 bus.out_data, edge_cnt);
      end else begin
        e  = exp_q.pop_front();
        le = lat_q.pop_front();
        if (bus.out_data !== e) begin
          n_err++;
          $display("FAIL out_data: got %h, required %h", bus.out_data, e);
        end
        n_cmp++;
        if (edge_cnt != le) begin
          n_err++;
          $display("FAIL latency: got result at edge %0d, required edge %0d", edge_cnt, le);
        end
      end
      last_out = bus.out_data;
    end else begin
      n_cmp++;
      if (bus.out_data !== last_out || bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold: got out_data=%h out_valid=%b, required %h and 0",
                 bus.out_data, bus.out_valid, last_out);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.in_bias  = '0;
    do_reset();

    beat(fill(word_t'(1)), word_t'(3), 1'b1);
    idle(L + 3);

    for (int i = 0; i < 10; i++) beat(fill(word_t'(i)), word_t'(0), 1'b1);
    idle(L + 3);

    beat(fill(word_t'(2)), word_t'(16'h1234), 1'b0);
    beat(fill(word_t'(3)), word_t'(16'h0F0F), 1'b0);
    beat(fill(word_t'(4)), word_t'(7), 1'b1);
    idle(L + 3);

    beat(fill(word_t'(16'h7FFF)), word_t'(0), 1'b1);
    beat(fill(word_t'(16'h8000)), word_t'(0), 1'b1);
    idle(L + 3);

    beat(rand_vec(), word_t'($urandom), 1'b0);
    beat(rand_vec(), word_t'($urandom), 1'b0);
    do_reset();
    beat(fill(word_t'(1)), word_t'(0), 1'b1);
    idle(L + 3);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      beat(rand_vec(), word_t'($urandom), ($urandom_range(0, 2) == 0));
    end
    beat(rand_vec(), word_t'($urandom), 1'b1);
    idle(L + 4);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results still outstanding, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
